// File: rtl/sysarray_pkg.sv
// Shared definitions for the systolic-array operand controller:
// FSM state encoding and the phase code that tells the array to load nothing.
package sysarray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int         FLG_W    = 7;
    localparam logic [6:0] FLG_IDLE = 7'h7F;

endpackage

// File: rtl/sysarray_opsel.sv
// Combinational slice selector: picks column sel_i (ROW_SEL=0) or row sel_i
// (ROW_SEL=1) out of a row-major packed n x n matrix.
module sysarray_opsel
    import sysarray_pkg::*;
#(
    parameter int N       = 31,
    parameter int n       = 3,
    parameter bit ROW_SEL = 1'b0
) (
    input  logic [(N+1)*n*n-1:0] mat_i,
    input  logic [FLG_W-1:0]     sel_i,
    output logic [(N+1)*n-1:0]   slice_o
);

    localparam int W = N + 1;

    // A one-hot compare per candidate index keeps every part-select constant.
    always_comb begin
        // NOTE: default assignment first so no path through the loops infers a latch.
        slice_o = '0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < n; k++) begin
                if (sel_i == FLG_W'(k)) begin
                    if (ROW_SEL) begin
                        slice_o[i*W +: W] = mat_i[(k*n + i)*W +: W];
                    end else begin
                        slice_o[i*W +: W] = mat_i[(i*n + k)*W +: W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sysarray_ctrl.sv
// Operand sequencer for an n x n systolic multiplier: captures A and B, streams
// column k of A and row k of B for n cycles, drains the array, then pulses done.
module sysarray_ctrl
    import sysarray_pkg::*;
#(
    parameter int N         = 31,
    parameter int n         = 3,
    parameter int DRAIN_CYC = 3*n    // n + DRAIN_CYC must stay <= 126 so flg never reaches FLG_IDLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [(N+1)*n*n-1:0] mat_a,
    input  logic [(N+1)*n*n-1:0] mat_b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           flg,
    output logic [(N+1)*n-1:0]   arr1,
    output logic [(N+1)*n-1:0]   arr2
);

    localparam int         MW     = (N+1)*n*n;
    localparam int         SW     = (N+1)*n;
    localparam logic [6:0] K_LAST = FLG_W'(n - 1);
    localparam logic [6:0] D_LAST = FLG_W'(DRAIN_CYC - 1);
    localparam logic [6:0] N_FLG  = FLG_W'(n);

    state_e          state_q, state_d;
    logic [6:0]      k_q, k_d;
    logic [6:0]      drn_q, drn_d;
    logic [MW-1:0]   a_q, a_d;
    logic [MW-1:0]   b_q, b_d;

    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [6:0]      flg_q, flg_d;
    logic [SW-1:0]   arr1_q, arr1_d;
    logic [SW-1:0]   arr2_q, arr2_d;

    logic [SW-1:0]   sel_a, sel_b;

    // Outputs are registered, so slices are taken from the next-cycle operand
    // copy and slice index; on the capture edge that is the incoming matrix.
    sysarray_opsel #(.N(N), .n(n), .ROW_SEL(1'b0)) u_sel_a (
        .mat_i   (a_d),
        .sel_i   (k_d),
        .slice_o (sel_a)
    );

    sysarray_opsel #(.N(N), .n(n), .ROW_SEL(1'b1)) u_sel_b (
        .mat_i   (b_d),
        .sel_i   (k_d),
        .slice_o (sel_b)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drn_d   = drn_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = mat_a;
                    b_d     = mat_b;
                    k_d     = '0;
                    drn_d   = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (k_q == K_LAST) begin
                    drn_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == D_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drn_d = drn_q + 7'd1;
                end
            end
            ST_DONE: begin
                k_d     = '0;
                drn_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        flg_d   = FLG_IDLE;
        arr1_d  = '0;
        arr2_d  = '0;

        case (state_d)
            ST_FEED: begin
                flg_d  = k_d;
                arr1_d = sel_a;
                arr2_d = sel_b;
            end
            ST_DRAIN: flg_d = N_FLG + drn_d;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state_q <= ST_IDLE;
            k_q     <= '0;
            drn_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flg_q   <= FLG_IDLE;
            arr1_q  <= '0;
            arr2_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flg_q   <= flg_d;
            arr1_q  <= arr1_d;
            arr2_q  <= arr2_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign flg   = flg_q;
    assign arr1  = arr1_q;
    assign arr2  = arr2_q;

endmodule
